sample_source: RTL and testbench
================================

SAMPLE_SOURCE -- requirements
Module: sample_source

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample and result width.
REQ-002 SHALL have parameter DEPTH, default 1024, sample/golden memory entries; AW = $clog2(DEPTH).
REQ-003 clk  input  1  sole clock, all logic on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ld_we  input  1  write strobe for sample memory, honoured in IDLE only.
REQ-006 ld_addr  input  AW  memory write address.
REQ-007 ld_in  input  DATA_W  input sample written at ld_addr.
REQ-008 ld_gold  input  DATA_W  golden output written at ld_addr.
REQ-009 num_samples  input  AW+1  samples per run, sampled on start; 1..DEPTH.
REQ-010 start  input  1  one-cycle pulse, begins run from IDLE.
REQ-011 next  input  1  consumer request for next sample pair.
REQ-012 ready  input  1  consumer result valid.
REQ-013 out_filt  input  DATA_W  consumer filtered output.
REQ-014 out_sse  input  DATA_W  consumer running SSE.
REQ-015 in  output  DATA_W  current input sample to consumer.
REQ-016 out_gold  output  DATA_W  current golden output to consumer.
REQ-017 stop  output  1  tells consumer stream ended.
REQ-018 done  output  1  run complete, level until next start.
REQ-019 sse_final  output  DATA_W  out_sse captured at last result.
REQ-020 overrun  output  1  sticky: next received after all samples issued.
REQ-021 mismatch_cnt  output  AW+1  results where out_filt != out_gold.

Function
REQ-022 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-023 IDLE: ld_we writes both memories; start latches num_samples, clears issue/result counters, overrun, mismatch_cnt, done, goes RUN.
REQ-024 start with num_samples 0 or >DEPTH SHALL go directly to DONE with done=1, stop=1.
REQ-025 RUN: on next high, in/out_gold SHALL present entry [issue_idx] exactly one cycle later and issue_idx SHALL increment.
REQ-026 next held high N cycles SHALL count as N requests (consumer pulses are one cycle).
REQ-027 When issue_idx reaches num_samples, SHALL go DRAIN; further next SHALL set overrun, drive in/out_gold to 0.
REQ-028 Result SHALL be counted on ready rising edge only (ready registered internally); out_sse captured into sse_final at that edge.
REQ-029 next and ready rising edge in same cycle SHALL both be serviced.
REQ-030 When result count equals num_samples (RUN or DRAIN), SHALL go DONE; stop and done SHALL assert the next cycle.
REQ-031 DONE: stop=1, done=1, outputs held; start SHALL begin a new run; ld_we ignored.
REQ-032 ld_we outside IDLE SHALL be ignored with no memory change.
REQ-033 Counters SHALL not wrap; result edges after count reached ignored.

Reset
REQ-034 rst SHALL force IDLE; in, out_gold, sse_final, mismatch_cnt = 0; stop, done, overrun = 0.
REQ-035 rst mid-run SHALL abort the run on that edge; memory contents SHALL be retained.

Configuration
REQ-036 Macro SAMPLE_SOURCE_MISMATCH_EN defined: at each counted result, compare out_filt with out_gold registered for that result, increment mismatch_cnt on inequality (saturating).
REQ-037 Macro undefined: no comparator, mismatch_cnt tied to 0.

Structure
REQ-038 Package fir_pkg SHALL hold DATA_W/DEPTH defaults and the state enum type.
REQ-039 Sub-module sample_ram SHALL hold both arrays: one synchronous write port, one registered read port, shared address.

Verification
REQ-040 Load 4 pairs (in 1,2,3,4; gold 10,20,30,40), num_samples=4, start, pulse next 4x -> in/out_gold 1/10..4/40, each one cycle after next.
REQ-041 Same run, ready pulses 4x with out_sse 5,9,12,100 -> after 4th, stop=1, done=1, sse_final=100.
REQ-042 num_samples=2, pulse next 3x -> third next sets overrun=1, in=0, out_gold=0.
REQ-043 ready held high 5 cycles -> exactly one result counted.
REQ-044 With macro, out_filt 10,21,30,41 vs gold 10,20,30,40 -> mismatch_cnt=2; without macro -> 0.
REQ-045 rst after 2 of 4 results -> IDLE, stop=0, done=0; restart reproduces sample 1/10 from intact memory.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the sample_source block.
// Contents:
//   DATA_W_DEF - default sample/result width
//   DEPTH_DEF  - default number of sample/golden memory entries
//   state_t    - run-control state encoding (IDLE, RUN, DRAIN, DONE)
package fir_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sample_source_if.sv
// Streaming link between sample_source and the filter under test.
// Signals:
//   in, out_gold  - sample / golden pair presented to the consumer
//   stop          - stream has ended
//   next          - consumer request for the next pair
//   ready         - consumer result valid (level; edge detected by source)
//   out_filt      - consumer filtered output
//   out_sse       - consumer running sum of squared errors
// Modports:
//   master - the sample source
//   slave  - the consumer
interface sample_source_if
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out_gold;
  logic              stop;
  logic              next;
  logic              ready;
  logic [DATA_W-1:0] out_filt;
  logic [DATA_W-1:0] out_sse;

  modport master (
    output in, out_gold, stop,
    input  next, ready, out_filt, out_sse
  );

  modport slave (
    input  in, out_gold, stop,
    output next, ready, out_filt, out_sse
  );

endinterface

// File: rtl/sample_ram.sv
// Paired sample/golden storage for sample_source.
// Two arrays (lane 0 = input samples, lane 1 = golden outputs) share one
// address. One synchronous write port, one registered read port.
// Ports:
//   clk      - clock
//   we       - write both lanes at addr
//   addr     - shared read/write address
//   wr_in    - sample data to write
//   wr_gold  - golden data to write
//   rd_en    - load read registers from addr
//   rd_clr   - synchronously clear read registers (has priority over rd_en)
//   rd_in    - registered sample read data
//   rd_gold  - registered golden read data
module sample_ram
  import fir_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_in,
  input  logic [DATA_W-1:0] wr_gold,
  input  logic              rd_en,
  input  logic              rd_clr,
  output logic [DATA_W-1:0] rd_in,
  output logic [DATA_W-1:0] rd_gold
);

  logic [1:0][DATA_W-1:0] wr_lane;
  logic [1:0][DATA_W-1:0] rd_lane_reg;
  logic                   addr_ok;

  assign wr_lane[0] = wr_in;
  assign wr_lane[1] = wr_gold;
  assign rd_in      = rd_lane_reg[0];
  assign rd_gold    = rd_lane_reg[1];

  // Non power-of-two depths leave part of the address space unbacked.
  assign addr_ok = ({1'b0, addr} < (AW + 1)'(DEPTH));

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we && addr_ok) begin
        mem[addr] <= wr_lane[gi];
      end
    end

    always_ff @(posedge clk) begin
      if (rd_clr) begin
        rd_lane_reg[gi] <= '0;
      end else if (rd_en) begin
        rd_lane_reg[gi] <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sample_source.sv
// Sample source: replays stored input samples and golden outputs to a
// filter under test, counts its results and captures the final SSE.
// Optional build macro: SAMPLE_SOURCE_MISMATCH_EN
//   defined   - each counted result compares out_filt with the golden
//               value currently presented; mismatch_cnt counts (saturating)
//   undefined - no comparator, mismatch_cnt is tied to 0
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   ld_we/ld_addr - memory load strobe and address (IDLE only)
//   ld_in/ld_gold - sample and golden value to store
//   num_samples   - samples per run, captured on start (1..DEPTH valid)
//   start         - begins a run from IDLE or DONE
//   stream        - consumer link (in/out_gold/stop out, next/ready/... in)
//   done          - run complete, held until the next start
//   sse_final     - out_sse captured at the most recent counted result
//   overrun       - sticky, next seen after every sample was issued
//   mismatch_cnt  - results whose out_filt differed from out_gold
module sample_source
  import fir_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_we,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_in,
  input  logic [DATA_W-1:0] ld_gold,
  input  logic [AW:0]       num_samples,
  input  logic              start,
  sample_source_if.master   stream,
  output logic              done,
  output logic [DATA_W-1:0] sse_final,
  output logic              overrun,
  output logic [AW:0]       mismatch_cnt
);

  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

  state_t            state_reg, state_next;
  logic [AW:0]       num_reg;
  logic [AW:0]       issue_idx_reg;
  logic [AW:0]       res_cnt_reg;
  logic              ready_reg;
  logic [DATA_W-1:0] sse_final_reg;
  logic              overrun_reg;

  logic              num_ok;
  logic              start_take;
  logic              ready_rise;
  logic              issue_hit;
  logic              issue_last;
  logic              over_hit;
  logic              res_hit;
  logic              res_last;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic              done_next;

  // ---------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------
  assign num_ok     = (num_samples != '0) && (num_samples <= (AW + 1)'(DEPTH));
  assign start_take = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign ready_rise = stream.ready && !ready_reg;

  // While in RUN, issue_idx is always below num, so a request is serviced.
  assign issue_hit  = (state_reg == ST_RUN) && stream.next;
  assign issue_last = (issue_idx_reg + CNT_ONE) == num_reg;
  assign over_hit   = (state_reg == ST_DRAIN) && stream.next;

  assign res_hit  = (state_reg == ST_RUN || state_reg == ST_DRAIN)
                    && ready_rise && (res_cnt_reg < num_reg);
  assign res_last = res_hit && ((res_cnt_reg + CNT_ONE) == num_reg);

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ram_we     = 1'b0;
    ram_addr   = issue_idx_reg[AW-1:0];
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ram_we   = ld_we;
        ram_addr = ld_addr;
        if (start) begin
          state_next = num_ok ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // A finished result count wins over the switch to DRAIN.
        if (res_last) begin
          state_next = ST_DONE;
        end else if (issue_hit && issue_last) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (res_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done_next = 1'b1;
        if (start) begin
          state_next = num_ok ? ST_RUN : ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign done        = done_next;
  assign stream.stop = done_next;

  // ---------------------------------------------------------------------
  // Counters and captured values
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      num_reg       <= '0;
      issue_idx_reg <= '0;
      res_cnt_reg   <= '0;
      ready_reg     <= 1'b0;
      sse_final_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      ready_reg <= stream.ready;
      if (start_take) begin
        num_reg       <= num_samples;
        issue_idx_reg <= '0;
        res_cnt_reg   <= '0;
        overrun_reg   <= 1'b0;
      end else begin
        if (issue_hit) begin
          issue_idx_reg <= issue_idx_reg + CNT_ONE;
        end
        if (over_hit) begin
          overrun_reg <= 1'b1;
        end
        if (res_hit) begin
          res_cnt_reg   <= res_cnt_reg + CNT_ONE;
          sse_final_reg <= stream.out_sse;
        end
      end
    end
  end

  assign sse_final = sse_final_reg;
  assign overrun   = overrun_reg;

  // ---------------------------------------------------------------------
  // Sample / golden storage. The read registers drive the stream directly;
  // an overrun request blanks them instead of reading.
  // ---------------------------------------------------------------------
  sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .addr    (ram_addr),
    .wr_in   (ld_in),
    .wr_gold (ld_gold),
    .rd_en   (issue_hit),
    .rd_clr  (rst || over_hit),
    .rd_in   (stream.in),
    .rd_gold (stream.out_gold)
  );

  // ---------------------------------------------------------------------
  // Optional result comparator
  // ---------------------------------------------------------------------
`ifdef SAMPLE_SOURCE_MISMATCH_EN
  logic [AW:0] mismatch_reg;

  // The golden value on out_gold at the counted edge is the one the
  // consumer was working against for this result.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_reg <= '0;
    end else if (start_take) begin
      mismatch_reg <= '0;
    end else if (res_hit && (stream.out_filt != stream.out_gold)
                 && (mismatch_reg != '1)) begin
      mismatch_reg <= mismatch_reg + CNT_ONE;
    end
  end

  assign mismatch_cnt = mismatch_reg;
`else
  logic unused_filt;

  assign unused_filt  = ^stream.out_filt;
  assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_sample_source.sv
// Self-checking bench for sample_source: directed scenarios plus
// randomized runs scored against a cycle-level behavioural model.
module tb_sample_source;
  import fir_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_in;
  logic [DW-1:0] ld_gold;
  logic [AW:0]   num_samples;
  logic          start;
  logic          done;
  logic [DW-1:0] sse_final;
  logic          overrun;
  logic [AW:0]   mismatch_cnt;

  sample_source_if #(.DATA_W(DW)) bus ();

  sample_source #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_in        (ld_in),
    .ld_gold      (ld_gold),
    .num_samples  (num_samples),
    .start        (start),
    .stream       (bus.master),
    .done         (done),
    .sse_final    (sse_final),
    .overrun      (overrun),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: memory image plus run bookkeeping by counts.
  logic [DW-1:0] m_mem_in   [DEPTH];
  logic [DW-1:0] m_mem_gold [DEPTH];
  int            m_n, m_issued, m_res, m_mism;
  bit            m_started, m_done, m_over, m_prev_rdy;
  logic [DW-1:0] m_in, m_gold, m_sse;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_mism();
`ifdef SAMPLE_SOURCE_MISMATCH_EN
    return m_mism;
`else
    return 0;
`endif
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, ".in"},       64'(bus.in),       64'(m_in));
    check_val({tag, ".gold"},     64'(bus.out_gold), 64'(m_gold));
    check_val({tag, ".stop"},     64'(bus.stop),     64'(m_done));
    check_val({tag, ".done"},     64'(done),         64'(m_done));
    check_val({tag, ".overrun"},  64'(overrun),      64'(m_over));
    check_val({tag, ".sse"},      64'(sse_final),    64'(m_sse));
    check_val({tag, ".mismatch"}, 64'(mismatch_cnt), 64'(exp_mism()));
  endtask

  task automatic idle_inputs();
    ld_we         = 1'b0;
    start         = 1'b0;
    bus.next      = 1'b0;
    bus.ready     = 1'b0;
    bus.out_filt  = '0;
    bus.out_sse   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_started = 0; m_done = 0; m_over = 0; m_prev_rdy = 0;
    m_n = 0; m_issued = 0; m_res = 0; m_mism = 0;
    m_in = '0; m_gold = '0; m_sse = '0;
    check_all("reset");
  endtask

  task automatic load(input int addr, input logic [DW-1:0] din, input logic [DW-1:0] dgold);
    idle_inputs();
    ld_we   = 1'b1;
    ld_addr = AW'(addr);
    ld_in   = din;
    ld_gold = dgold;
    step();
    ld_we = 1'b0;
    m_prev_rdy = 0;
    if (!m_started) begin
      m_mem_in[addr]   = din;
      m_mem_gold[addr] = dgold;
    end
  endtask

  task automatic start_run(input int n);
    idle_inputs();
    start       = 1'b1;
    num_samples = (AW + 1)'(n);
    step();
    start = 1'b0;
    m_prev_rdy = 0;
    if (!m_started || m_done) begin
      m_over = 0;
      m_mism = 0;
      if (n >= 1 && n <= DEPTH) begin
        m_started = 1; m_done = 0;
        m_n = n; m_issued = 0; m_res = 0;
      end else begin
        m_started = 1; m_done = 1;
      end
    end
    check_all("start");
  endtask

  // One clock with the given consumer inputs, then model update and check.
  task automatic cycle(input bit nx, input bit rd, input logic [DW-1:0] filt,
                       input logic [DW-1:0] sse);
    bus.next     = nx;
    bus.ready    = rd;
    bus.out_filt = filt;
    bus.out_sse  = sse;
    step();
    if (m_started && !m_done) begin
      if (rd && !m_prev_rdy && m_res < m_n) begin
        m_res++;
        m_sse = sse;
        if (filt != m_gold) m_mism++;
      end
      if (nx) begin
        if (m_issued < m_n) begin
          m_in   = m_mem_in[m_issued];
          m_gold = m_mem_gold[m_issued];
          m_issued++;
        end else begin
          m_over = 1;
          m_in   = '0;
          m_gold = '0;
        end
      end
      if (m_res == m_n) m_done = 1;
    end
    m_prev_rdy = rd;
    check_all("cyc");
  endtask

  initial begin
    logic [DW-1:0] sse_tab  [4];
    logic [DW-1:0] filt_tab [4];
    sse_tab  = '{32'd5, 32'd9, 32'd12, 32'd100};
    filt_tab = '{32'd10, 32'd21, 32'd30, 32'd41};
    rst = 1'b0;
    ld_addr = '0; ld_in = '0; ld_gold = '0; num_samples = '0;
    idle_inputs();

    // Reset state
    do_reset();

    // Basic run: 1..4 / 10..40, interleaved request and result
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 4) load(i, DW'(i + 1), DW'((i + 1) * 10));
      else       load(i, $urandom, $urandom);
    end
    start_run(4);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, '0, '0);
      check_val("basic_in",   64'(bus.in),       64'(i + 1));
      check_val("basic_gold", 64'(bus.out_gold), 64'((i + 1) * 10));
      cycle(1'b0, 1'b1, filt_tab[i], sse_tab[i]);
      check_val("basic_done", 64'(done), 64'(i == 3));
    end
    check_val("basic_stop_end", 64'(bus.stop),  64'd1);
    check_val("basic_sse_end",  64'(sse_final), 64'd100);
`ifdef SAMPLE_SOURCE_MISMATCH_EN
    check_val("basic_mismatch", 64'(mismatch_cnt), 64'd2);
`else
    check_val("basic_mismatch", 64'(mismatch_cnt), 64'd0);
`endif

    // Load while DONE must not reach memory
    load(0, 32'd99, 32'd990);

    // Overrun after two samples, then held ready counts once
    start_run(2);
    cycle(1'b1, 1'b0, '0, '0);
    check_val("done_load_ignored", 64'(bus.in), 64'd1);
    cycle(1'b1, 1'b0, '0, '0);
    check_val("pre_overrun", 64'(overrun), 64'd0);
    cycle(1'b1, 1'b0, '0, '0);
    check_val("overrun_flag", 64'(overrun),      64'd1);
    check_val("overrun_in",   64'(bus.in),       64'd0);
    check_val("overrun_gold", 64'(bus.out_gold), 64'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0, DW'(i + 7));
    check_val("held_ready_once", 64'(done),      64'd0);
    check_val("held_ready_sse",  64'(sse_final), 64'd7);
    cycle(1'b0, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, '0, 32'd55);
    check_val("second_result_done", 64'(done), 64'd1);

    // Out-of-range sample counts finish at once
    do_reset();
    start_run(0);
    check_val("num0_done", 64'(done),     64'd1);
    check_val("num0_stop", 64'(bus.stop), 64'd1);
    do_reset();
    start_run(DEPTH + 1);
    check_val("numbig_done", 64'(done), 64'd1);

    // Randomized runs against the model
    for (int it = 0; it < 12; it++) begin
      int n;
      do_reset();
      for (int a = 0; a < DEPTH; a++) load(a, $urandom, $urandom);
      n = (it == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
      start_run(n);
      for (int c = 0; c < 4 * n + 12; c++) begin
        bit nx, rd;
        logic [DW-1:0] filt;
        nx   = ($urandom_range(0, 2) == 0);
        rd   = $urandom_range(0, 1) == 1;
        filt = ($urandom_range(0, 1) == 1) ? m_gold : DW'($urandom);
        cycle(nx, rd, filt, DW'($urandom));
      end
      load(int'($urandom_range(0, DEPTH - 1)), $urandom, $urandom);
      check_all("post_load");
    end

    // Reset in mid-run keeps memory
    do_reset();
    for (int i = 0; i < 4; i++) load(i, DW'(i + 1), DW'((i + 1) * 10));
    start_run(4);
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 32'd10, 32'd3);
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 32'd20, 32'd4);
    do_reset();
    check_val("midrst_stop", 64'(bus.stop), 64'd0);
    check_val("midrst_done", 64'(done),     64'd0);
    start_run(4);
    cycle(1'b1, 1'b0, '0, '0);
    check_val("restart_in",   64'(bus.in),       64'd1);
    check_val("restart_gold", 64'(bus.out_gold), 64'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
